g07_slave_responder: RTL and testbench



---
 rtl/g07_slave_responder.sv | 154 +++++++++++++++
 tb/tb_g07_slave_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/g07_slave_responder.sv
// Slave-side endpoint behind the g07 arbiter: decodes its address window, runs a
// wait-stated word access to a local register file and returns a one-cycle Tdone.
module g07_slave_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'hfffe7637,
    parameter logic [63:0] LIMIT_ADDR  = 64'hfffe7643,
    parameter int          DATA_W      = 32,
    parameter int          WAIT_STATES = 2
) (
    input  logic              sysClk,
    input  logic              Breset,
    input  logic              en,
    input  logic [63:0]       addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              Tdone,
    output logic              err
);

    localparam logic [63:0] DEPTH_W64 = LIMIT_ADDR - BASE_ADDR + 64'd1;
    localparam int          DEPTH     = int'(DEPTH_W64);
    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [63:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oor_q, oor_d;
    logic              tdone_q, tdone_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              mem_fire;
    logic              rd_clear;
    logic              mem_we;
    logic              mem_re;

    assign in_range = (addr >= BASE_ADDR) && (addr <= LIMIT_ADDR);
    assign idx      = IDX_W'(addr_q - BASE_ADDR);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        oor_d    = oor_q;
        tdone_d  = 1'b0;
        err_d    = 1'b0;
        mem_fire = 1'b0;
        rd_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    wdata_d = wdata;
                    oor_d   = ~in_range;
                    // Out-of-window requests take a zero-wait pass through ACCESS,
                    // so their Tdone/err land one edge after acceptance.
                    cnt_d   = in_range ? WAIT_CNT : 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    tdone_d = 1'b1;
                    state_d = DONE;
                    if (oor_q) begin
                        err_d    = 1'b1;
                        rd_clear = 1'b1;
                    end else begin
                        mem_fire = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = en ? HOLD : IDLE;
            end
            HOLD: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_we = Breset && mem_fire && wr_q;
    assign mem_re = Breset && mem_fire && !wr_q;

    always_ff @(posedge sysClk) begin
        if (!Breset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 64'd0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            tdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            tdone_q <= tdone_d;
            err_q   <= err_d;
        end
    end

    // Register file is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge sysClk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge sysClk) begin
        if (!Breset) begin
            rdata_q <= '0;
        end else if (mem_re) begin
            rdata_q <= mem_q[idx];
        end else if (rd_clear) begin
            rdata_q <= '0;
        end
    end

    assign rdata = rdata_q;
    assign Tdone = tdone_q;
    assign err   = err_q;

endmodule

// File: tb/tb_g07_slave_responder.sv
// Directed bench for g07_slave_responder: a 2-wait-state instance and a
// 0-wait-state instance share stimulus, selected by sel.
module tb_g07_slave_responder;

    logic        clk = 1'b0;
    logic        Breset;
    logic        en;
    logic        sel;
    logic [63:0] addr;
    logic        wr;
    logic [31:0] wdata;

    logic        en_a, en_b;
    logic [31:0] rdata_a, rdata_b, rdata_m;
    logic        tdone_a, tdone_b, tdone_m;
    logic        err_a, err_b, err_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign en_a    = en & ~sel;
    assign en_b    = en & sel;
    assign rdata_m = sel ? rdata_b : rdata_a;
    assign tdone_m = sel ? tdone_b : tdone_a;
    assign err_m   = sel ? err_b   : err_a;

    g07_slave_responder #(
        .BASE_ADDR  (64'hfffe7637),
        .LIMIT_ADDR (64'hfffe7643),
        .DATA_W     (32),
        .WAIT_STATES(2)
    ) dut (
        .sysClk(clk),
        .Breset(Breset),
        .en    (en_a),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata_a),
        .Tdone (tdone_a),
        .err   (err_a)
    );

    g07_slave_responder #(
        .BASE_ADDR  (64'hfffe7637),
        .LIMIT_ADDR (64'hfffe7643),
        .DATA_W     (32),
        .WAIT_STATES(0)
    ) dut0 (
        .sysClk(clk),
        .Breset(Breset),
        .en    (en_b),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .rdata (rdata_b),
        .Tdone (tdone_b),
        .err   (err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a posedge; the next posedge is edge 0 (en sampled).
    // Inputs are scrambled after edge 0 to show captured values are used.
    task automatic xfer(input string tag, input logic w, input logic [63:0] a,
                        input logic [31:0] d, input int exp_edge, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        en = 1'b1; wr = w; addr = a; wdata = d;
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                wr = ~w; addr = ~a; wdata = ~d;
            end
            if (tdone_m) begin
                pulses++;
                if (first < 0) begin
                    first = e;
                    check({tag, "_err"}, 64'(err_m), 64'(exp_err));
                    if (chk_rd) check({tag, "_rdata"}, 64'(rdata_m), 64'(exp_rd));
                end
                en = 1'b0;
            end
        end
        en = 1'b0;
        check({tag, "_edge"}, 64'(first), 64'(exp_edge));
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        $display("xfer %s wr=%0b addr=%h edge=%0d pulses=%0d err=%0b rdata=%h",
                 tag, w, a, first, pulses, err_m, rdata_m);
    endtask

    initial begin
        int pulses;
        Breset = 1'b0; en = 1'b0; sel = 1'b0;
        addr = 64'd0; wr = 1'b0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tdone", 64'(tdone_a), 64'd0);
        check("rst_err",   64'(err_a),   64'd0);
        check("rst_rdata", 64'(rdata_a), 64'd0);
        check("rst0_tdone", 64'(tdone_b), 64'd0);
        check("rst0_rdata", 64'(rdata_b), 64'd0);
        Breset = 1'b1;
        @(posedge clk); #1;

        // Basic write/read at the base address
        xfer("wr_base", 1'b1, 64'hfffe7637, 32'hA5A5_0001, 3, 1'b0, 1'b0, 32'd0);
        xfer("rd_base", 1'b0, 64'hfffe7637, 32'd0,         3, 1'b0, 1'b1, 32'hA5A5_0001);
        xfer("wr_lim",  1'b1, 64'hfffe7643, 32'h0000_C0DE, 3, 1'b0, 1'b0, 32'd0);
        xfer("rd_lim",  1'b0, 64'hfffe7643, 32'd0,         3, 1'b0, 1'b1, 32'h0000_C0DE);

        // Just outside the window
        xfer("wr_above", 1'b1, 64'hfffe7644, 32'hDEAD_BEEF, 1, 1'b1, 1'b1, 32'd0);
        xfer("rd_lim2",  1'b0, 64'hfffe7643, 32'd0,         3, 1'b0, 1'b1, 32'h0000_C0DE);
        xfer("rd_above", 1'b0, 64'hfffe7644, 32'd0,         1, 1'b1, 1'b1, 32'd0);
        xfer("wr_below", 1'b1, 64'hfffe7636, 32'hBAD0_BAD0, 1, 1'b1, 1'b1, 32'd0);
        xfer("rd_base2", 1'b0, 64'hfffe7637, 32'd0,         3, 1'b0, 1'b1, 32'hA5A5_0001);
        xfer("rd_lim3",  1'b0, 64'hfffe7643, 32'd0,         3, 1'b0, 1'b1, 32'h0000_C0DE);

        // Abort: en dropped so that edge 2 sees it low while in ACCESS
        xfer("wr_38", 1'b1, 64'hfffe7638, 32'h1111_1111, 3, 1'b0, 1'b0, 32'd0);
        en = 1'b1; wr = 1'b1; addr = 64'hfffe7638; wdata = 32'h2222_2222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b0;
        pulses = 0;
        for (int e = 2; e <= 8; e++) begin
            @(posedge clk); #1;
            if (tdone_m) pulses++;
        end
        check("abort_pulses", 64'(pulses), 64'd0);
        $display("xfer abort addr=fffe7638 pulses=%0d", pulses);
        xfer("rd_38", 1'b0, 64'hfffe7638, 32'd0, 3, 1'b0, 1'b1, 32'h1111_1111);

        // Reset in the middle of a write
        xfer("wr_3a", 1'b1, 64'hfffe763A, 32'h3333_3333, 3, 1'b0, 1'b0, 32'd0);
        xfer("rd_3a", 1'b0, 64'hfffe763A, 32'd0,         3, 1'b0, 1'b1, 32'h3333_3333);
        en = 1'b1; wr = 1'b1; addr = 64'hfffe763A; wdata = 32'h4444_4444;
        @(posedge clk); #1;
        @(posedge clk); #1;
        Breset = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        check("midrst_tdone", 64'(tdone_m), 64'd0);
        check("midrst_err",   64'(err_m),   64'd0);
        check("midrst_rdata", 64'(rdata_m), 64'd0);
        @(posedge clk); #1;
        Breset = 1'b1;
        pulses = 0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            if (tdone_m) pulses++;
        end
        check("midrst_pulses", 64'(pulses), 64'd0);
        $display("xfer reset_abort addr=fffe763a pulses=%0d", pulses);
        xfer("rd_3a_post", 1'b0, 64'hfffe763A, 32'd0, 3, 1'b0, 1'b1, 32'h3333_3333);

        // Hold: en stays high well past Tdone
        en = 1'b1; wr = 1'b0; addr = 64'hfffe7637;
        pulses = 0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            if (tdone_m) pulses++;
        end
        check("hold_pulses", 64'(pulses), 64'd1);
        check("hold_rdata", 64'(rdata_m), 64'hA5A5_0001);
        $display("xfer hold addr=fffe7637 pulses=%0d rdata=%h", pulses, rdata_m);
        en = 1'b0;
        @(posedge clk); #1;
        xfer("rd_after_hold", 1'b0, 64'hfffe7643, 32'd0, 3, 1'b0, 1'b1, 32'h0000_C0DE);

        // Zero-wait-state instance
        sel = 1'b1;
        @(posedge clk); #1;
        xfer("ws0_wr", 1'b1, 64'hfffe7640, 32'h5555_AAAA, 1, 1'b0, 1'b0, 32'd0);
        xfer("ws0_rd", 1'b0, 64'hfffe7640, 32'd0,         1, 1'b0, 1'b1, 32'h5555_AAAA);
        xfer("ws0_oor", 1'b0, 64'hfffe7644, 32'd0,        1, 1'b1, 1'b1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
